// File: rtl/kcpsmx_issue_pkg.sv
// Shared KCPSM3 decode definitions for the issue stage: opcodes, shift codes,
// instruction field positions and opcode classification helpers.
package kcpsmx3_inc;

  localparam int OPERAND_WIDTH = 8;

  localparam int OPCODE_MSB      = 17;
  localparam int OPCODE_LSB      = 13;
  localparam int OPB_SEL_BIT     = 12;
  localparam int SX_MSB          = 11;
  localparam int SX_LSB          = 8;
  localparam int SY_MSB          = 7;
  localparam int SY_LSB          = 4;
  localparam int KK_MSB          = 7;
  localparam int KK_LSB          = 0;
  localparam int SHIFT_DIR_BIT   = 3;
  localparam int SHIFT_OP_MSB    = 2;
  localparam int SHIFT_OP_LSB    = 1;
  localparam int SHIFT_CONST_BIT = 0;

  typedef enum logic [4:0] {
    OP_LOAD    = 5'h00,
    OP_AND     = 5'h05,
    OP_OR      = 5'h06,
    OP_XOR     = 5'h07,
    OP_TEST    = 5'h09,
    OP_COMPARE = 5'h0A,
    OP_ADD     = 5'h0C,
    OP_ADDCY   = 5'h0D,
    OP_SUB     = 5'h0E,
    OP_SUBCY   = 5'h0F,
    OP_RS      = 5'h10
  } opcode_t;

  // Names pair the right/left variants that share a fill-bit source.
  typedef enum logic [1:0] {
    SHIFT_SA     = 2'b00,
    SHIFT_RL_SRX = 2'b01,
    SHIFT_RR_SLX = 2'b10,
    SHIFT_SC     = 2'b11
  } shift_op_t;

  function automatic logic is_alu_op(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_TEST, OP_COMPARE,
      OP_ADD, OP_ADDCY, OP_SUB, OP_SUBCY, OP_RS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_sx(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDCY,
      OP_SUB, OP_SUBCY, OP_RS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic updates_flags(input logic [4:0] op);
    return is_alu_op(op) && (op != OP_LOAD);
  endfunction

endpackage

// File: rtl/kcpsmx_issue_regfile.sv
// s0..sF register file: two registered read ports, one write port.
// A read and write of the same register on one edge returns the old value.
module kcpsmx_regfile #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      if (rd_en) begin
        rd_data_a <= regs[rd_addr_a];
        rd_data_b <= regs[rd_addr_b];
      end
    end
  end

endmodule

// File: rtl/kcpsmx_issue.sv
// KCPSM3 decode/issue + writeback stage in front of kcpsmx_alu.
// Define KCPSMX_ISSUE_FWD_EN for a RAW bypass; otherwise RAW hazards stall one cycle.
module kcpsmx_issue
  import kcpsmx3_inc::*;
#(
  parameter int INSTR_WIDTH = 18,
  parameter int NUM_REGS    = 16,
  localparam int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic                     flush,
  input  logic                     hold,
  output opcode_t                  alu_operation,
  output shift_op_t                alu_shift_operation,
  output logic                     alu_shift_direction,
  output logic                     alu_shift_constant,
  output logic [OPERAND_WIDTH-1:0] alu_operand_a,
  output logic [OPERAND_WIDTH-1:0] alu_operand_b,
  output logic                     alu_carry_in,
  input  logic [OPERAND_WIDTH-1:0] alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  output logic                     zero_flag,
  output logic                     carry_flag,
  output logic                     wb_valid,
  output logic [REG_ADDR_W-1:0]    wb_addr,
  output logic [OPERAND_WIDTH-1:0] wb_data,
  output logic                     unsup_pulse
);

  logic [4:0]               in_op;
  logic                     in_sel;
  logic [REG_ADDR_W-1:0]    in_sx, in_sy;
  logic [7:0]               in_kk;

  logic                     e_valid, e_sel;
  logic [4:0]               e_op;
  logic [REG_ADDR_W-1:0]    e_sx;
  logic [7:0]               e_kk;

  logic                     accept, retire, raw_stall;
  logic                     fwd_a, fwd_b;
  logic [OPERAND_WIDTH-1:0] fwd_data;
  logic [OPERAND_WIDTH-1:0] rd_a, rd_b;

  assign in_op  = instr[OPCODE_MSB:OPCODE_LSB];
  assign in_sel = instr[OPB_SEL_BIT];
  assign in_sx  = instr[SX_MSB:SX_LSB];
  assign in_sy  = instr[SY_MSB:SY_LSB];
  assign in_kk  = instr[KK_MSB:KK_LSB];

  assign instr_ready = !reset && !flush && !(e_valid && hold) && !raw_stall;
  assign accept      = instr_valid && instr_ready;
  assign retire      = e_valid && !hold && !flush && !reset;

  assign wb_valid    = retire && writes_sx(e_op);
  assign wb_addr     = wb_valid ? e_sx : '0;
  assign wb_data     = wb_valid ? alu_result : '0;
  assign unsup_pulse = retire && !is_alu_op(e_op);

`ifdef KCPSMX_ISSUE_FWD_EN
  assign raw_stall = 1'b0;

  // The register being written this edge is not visible through the
  // registered read, so the incoming ALU result is captured alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a    <= 1'b0;
      fwd_b    <= 1'b0;
      fwd_data <= '0;
    end else if (accept) begin
      fwd_a    <= wb_valid && (in_sx == e_sx);
      fwd_b    <= wb_valid && in_sel && (in_sy == e_sx);
      fwd_data <= alu_result;
    end
  end
`else
  assign raw_stall = e_valid && instr_valid && writes_sx(e_op) &&
                     ((in_sx == e_sx) || (in_sel && (in_sy == e_sx)));
  assign fwd_a    = 1'b0;
  assign fwd_b    = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_op    <= '0;
      e_sel   <= 1'b0;
      e_sx    <= '0;
      e_kk    <= '0;
    end else begin
      if (flush)       e_valid <= 1'b0;
      else if (accept) e_valid <= 1'b1;
      else if (retire) e_valid <= 1'b0;
      if (accept) begin
        e_op  <= in_op;
        e_sel <= in_sel;
        e_sx  <= in_sx;
        e_kk  <= in_kk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (retire && updates_flags(e_op)) begin
      zero_flag  <= alu_zero;
      carry_flag <= alu_carry;
    end
  end

  kcpsmx_regfile #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (REG_ADDR_W),
    .DATA_W   (OPERAND_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (accept),
    .rd_addr_a (in_sx),
    .rd_addr_b (in_sy),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b),
    .wr_en     (wb_valid),
    .wr_addr   (e_sx),
    .wr_data   (alu_result)
  );

  // Unsupported opcodes present a harmless LOAD to the ALU.
  assign alu_operation       = is_alu_op(e_op) ? opcode_t'(e_op) : OP_LOAD;
  assign alu_shift_direction = (e_op == OP_RS) ? e_kk[SHIFT_DIR_BIT] : 1'b0;
  assign alu_shift_operation = (e_op == OP_RS) ? shift_op_t'(e_kk[SHIFT_OP_MSB:SHIFT_OP_LSB])
                                               : SHIFT_SA;
  assign alu_shift_constant  = (e_op == OP_RS) ? e_kk[SHIFT_CONST_BIT] : 1'b0;
  assign alu_operand_a       = fwd_a ? fwd_data : rd_a;
  assign alu_operand_b       = e_sel ? (fwd_b ? fwd_data : rd_b) : e_kk;
  assign alu_carry_in        = carry_flag;

endmodule
